stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Control sequencer for the lab3 stopwatch.
- Sits between the clock-divider strobes and the raw board inputs (pause button, ADJ/SEL switches) on one side, and the minutes/seconds counters and display blanking on the other.
- Owns the run/pause/adjust state machine and issues single-cycle increment pulses and blink enables.
- Counters wrap themselves (seconds 59->0, minutes 59->0).

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles the synchronized button level must stay stable before it is accepted (5 ms at 100 MHz; bench uses 4).
- DB_CNT_W, 19, width of the debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- master_clk  input  1  system clock, single clock domain.
- rst  input  1  reset, asynchronous, active-high.
- pause_btn  input  1  raw pause push-button (but0), asynchronous, bouncy.
- adj  input  1  raw ADJ switch (sw0); 1 = adjust mode.
- sel  input  1  raw SEL switch (sw1); 0 = adjust minutes, 1 = adjust seconds.
- tick_1hz  input  1  one-cycle strobe, 1 Hz.
- tick_2hz  input  1  one-cycle strobe, 2 Hz.
- tick_blink  input  1  one-cycle strobe at blink rate.
- sec_max  input  1  seconds counter currently equals 59.
- sec_inc  output  1  one-cycle increment pulse to the seconds counter.
- min_inc  output  1  one-cycle increment pulse to the minutes counter.
- paused  output  1  pause flag.
- mode  output  2  current state encoding.
- blink_min  output  1  blank the minutes digits this cycle.
- blink_sec  output  1  blank the seconds digits this cycle.

Behaviour:
- **Reset:**
  - All registers clear asynchronously.
  - Outputs at reset: sec_inc=0, min_inc=0, paused=0, mode=RUN, blink_min=0, blink_sec=0, blink_phase=0.
  - Synchronizer flops and debounce state clear to 0.
  - Reset mid-operation aborts any pending debounce or pulse immediately.
- **Input conditioning:**
  - pause_btn, adj and sel each pass through a 2-flop synchronizer giving pb_s, adj_s, sel_s.
  - pb_s feeds the debouncer: a counter restarts whenever pb_s differs from the debounced level pb_db.
  - When pb_s has stayed different for DEBOUNCE_CYCLES consecutive cycles, pb_db takes pb_s and the counter clears.
  - pause_evt = one-cycle pulse on the rising edge of pb_db. Falling edges are ignored.
- **States (mode):** RUN=2'd0, ADJUST=2'd1. Encodings 2'd2 and 2'd3 are unused and recover to RUN on the next clock.
- **Transitions (registered):**
  - RUN -> ADJUST when adj_s=1.
  - ADJUST -> RUN when adj_s=0.
  - adj_s takes priority over everything else.
- **Pause flag:**
  - Toggles on pause_evt in either state.
  - Independent of mode: leaving ADJUST restores the run/pause condition held before.
- **Increments** (registered, asserted the cycle after the qualifying strobe, exactly 1 cycle wide):
  - RUN, paused=0, tick_1hz: sec_inc=1, and min_inc=sec_max (carry).
  - ADJUST, paused=0, tick_2hz:
    - sel_s=0: min_inc=1, sec_inc=0.
    - sel_s=1: sec_inc=1, min_inc=0.
    - No carry in ADJUST.
  - tick_1hz is ignored in ADJUST; tick_2hz is ignored in RUN.
  - paused=1 suppresses all increments.
- **Simultaneous events:**
  - A strobe coinciding with pause_evt or a mode change is evaluated with the pre-update paused and mode values.
  - sec_inc and min_inc are never asserted on two consecutive cycles from one strobe.
- **Blink:**
  - blink_phase toggles on tick_blink while mode=ADJUST; it is forced to 0 in RUN.
  - blink_min = ADJUST & ~sel_s & blink_phase.
  - blink_sec = ADJUST & sel_s & blink_phase.
  - Both outputs are registered.
- **Pause in adjust:** blink continues while paused in ADJUST; only increments freeze.

Decomposition:
- **stopwatch_pkg:** state encodings MODE_RUN and MODE_ADJUST, and the DEBOUNCE_CYCLES default.
- **btn_debounce sub-module:** 2-flop synchronizer, stable-count debouncer and rising-edge pulse.
  - Ports: master_clk, rst, raw, level, rise_pulse.
  - Parameters: DEBOUNCE_CYCLES, DB_CNT_W.
  - Instantiated once for pause_btn; adj and sel use plain synchronizers inside stopwatch_ctrl.

Test Plan (DEBOUNCE_CYCLES=4):
1. **Reset.** Assert rst asynchronously between clock edges -> all outputs 0 and mode=0 before the next edge; hold 0 through release.
2. **Run with carry.** RUN, sec_max=0, one tick_1hz -> exactly one cycle of sec_inc=1, min_inc=0, one cycle after the strobe. Repeat with sec_max=1 -> sec_inc=1 and min_inc=1 on the same cycle.
3. **Debounce.**
   - Bounce pause_btn 1/0/1 with 2-cycle spacing, then hold 1 -> paused goes 1 exactly 2+4+1 cycles after the final rising edge; no intermediate toggles.
   - Subsequent tick_1hz strobes -> no sec_inc.
   - Release and press again cleanly -> paused=0.
4. **Adjust minutes.**
   - adj=1, sel=0, paused=0, tick_2hz every 10 cycles -> min_inc pulses each time, sec_inc stays 0.
   - tick_1hz strobes and sec_max=1 -> no effect.
   - tick_blink strobes -> blink_min alternates 1/0; blink_sec stays 0.
5. **Adjust seconds, paused.**
   - adj=1, sel=1, paused=1 -> tick_2hz produces no pulses; blink_sec still toggles.
   - Clear adj -> mode=RUN, blink outputs 0, paused remains 1.
6. **Simultaneous events.**
   - tick_1hz in the same cycle as pause_evt, starting from paused=0 -> one sec_inc issued, then paused=1.
   - tick_2hz in the same cycle adj_s falls -> the adjust increment is still issued.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the lab3 stopwatch control sequencer: mode encodings
// and the default debounce window for a 100 MHz board clock.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        MODE_RUN    = 2'd0,
        MODE_ADJUST = 2'd1
    } mode_e;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int DB_CNT_W_DEFAULT        = 19;

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stable-count debouncer and a
// registered one-cycle pulse issued on the same edge the debounced level rises.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int DB_CNT_W        = DB_CNT_W_DEFAULT
) (
    input  logic master_clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    logic [1:0]          sync_q;
    logic [DB_CNT_W-1:0] cnt_q, cnt_d;
    logic                level_q, level_d;
    logic                rise_q, rise_d;
    logic                synced;

    assign synced = sync_q[1];

    // The counter only runs while the synchronized input disagrees with the
    // accepted level; any agreement restarts the stability window.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (synced != level_q) begin
            if (cnt_q == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = synced;
                rise_d  = synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge master_clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level      = level_q;
    assign rise_pulse = rise_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/adjust sequencer for the lab3 stopwatch: turns divider strobes and
// board inputs into one-cycle counter increments and digit blink enables.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int DB_CNT_W        = DB_CNT_W_DEFAULT
) (
    input  logic       master_clk,
    input  logic       rst,
    input  logic       pause_btn,
    input  logic       adj,
    input  logic       sel,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       tick_blink,
    input  logic       sec_max,
    output logic       sec_inc,
    output logic       min_inc,
    output logic       paused,
    output logic [1:0] mode,
    output logic       blink_min,
    output logic       blink_sec
);

    logic       pb_db, pb_rise, pause_evt;
    logic [1:0] sw_meta_q, sw_sync_q;
    logic       adj_s, sel_s;

    logic [1:0] mode_q, mode_d;
    logic       paused_q, paused_d;
    logic       sec_inc_q, sec_inc_d;
    logic       min_inc_q, min_inc_d;
    logic       phase_q, phase_d;
    logic       blink_min_q, blink_min_d;
    logic       blink_sec_q, blink_sec_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DB_CNT_W       (DB_CNT_W)
    ) u_pause_db (
        .master_clk(master_clk),
        .rst       (rst),
        .raw       (pause_btn),
        .level     (pb_db),
        .rise_pulse(pb_rise)
    );

    // The rise pulse and the level update on the same edge, so this gate is
    // transparent; it only guards against a pulse without an accepted press.
    assign pause_evt = pb_rise & pb_db;

    assign adj_s = sw_sync_q[0];
    assign sel_s = sw_sync_q[1];

    // Strobes are judged against the current (pre-update) mode and pause flag.
    always_comb begin
        mode_d    = MODE_RUN;
        paused_d  = paused_q ^ pause_evt;
        sec_inc_d = 1'b0;
        min_inc_d = 1'b0;
        phase_d   = 1'b0;
        case (mode_q)
            MODE_RUN: begin
                mode_d = adj_s ? MODE_ADJUST : MODE_RUN;
                if (!paused_q && tick_1hz) begin
                    sec_inc_d = 1'b1;
                    min_inc_d = sec_max;
                end
            end
            MODE_ADJUST: begin
                mode_d  = adj_s ? MODE_ADJUST : MODE_RUN;
                phase_d = phase_q ^ tick_blink;
                if (!paused_q && tick_2hz) begin
                    sec_inc_d = sel_s;
                    min_inc_d = ~sel_s;
                end
            end
            default: mode_d = MODE_RUN;
        endcase
        blink_min_d = (mode_d == MODE_ADJUST) & ~sel_s & phase_d;
        blink_sec_d = (mode_d == MODE_ADJUST) &  sel_s & phase_d;
    end

    always_ff @(posedge master_clk or posedge rst) begin
        if (rst) begin
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
            mode_q      <= MODE_RUN;
            paused_q    <= 1'b0;
            sec_inc_q   <= 1'b0;
            min_inc_q   <= 1'b0;
            phase_q     <= 1'b0;
            blink_min_q <= 1'b0;
            blink_sec_q <= 1'b0;
        end else begin
            sw_meta_q   <= {sel, adj};
            sw_sync_q   <= sw_meta_q;
            mode_q      <= mode_d;
            paused_q    <= paused_d;
            sec_inc_q   <= sec_inc_d;
            min_inc_q   <= min_inc_d;
            phase_q     <= phase_d;
            blink_min_q <= blink_min_d;
            blink_sec_q <= blink_sec_d;
        end
    end

    assign sec_inc   = sec_inc_q;
    assign min_inc   = min_inc_q;
    assign paused    = paused_q;
    assign mode      = mode_q;
    assign blink_min = blink_min_q;
    assign blink_sec = blink_sec_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios with literal
// expectations, then random stimulus checked every cycle against a model.
module tb_stopwatch_ctrl;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pause_btn = 1'b0, adj = 1'b0, sel = 1'b0;
    logic       tick_1hz = 1'b0, tick_2hz = 1'b0, tick_blink = 1'b0, sec_max = 1'b0;
    logic       sec_inc, min_inc, paused, blink_min, blink_sec;
    logic [1:0] mode;

    int pass_cnt = 0;
    int total_cnt = 0;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(DB), .DB_CNT_W(3)) dut (
        .master_clk(clk),
        .rst       (rst),
        .pause_btn (pause_btn),
        .adj       (adj),
        .sel       (sel),
        .tick_1hz  (tick_1hz),
        .tick_2hz  (tick_2hz),
        .tick_blink(tick_blink),
        .sec_max   (sec_max),
        .sec_inc   (sec_inc),
        .min_inc   (min_inc),
        .paused    (paused),
        .mode      (mode),
        .blink_min (blink_min),
        .blink_sec (blink_sec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model: inputs seen two edges late, debounced by run length,
    // strobes judged against the previous pause/mode, outputs one edge later.
    bit m_pb1, m_pb2, m_adj1, m_adj2, m_sel1, m_sel2;
    bit m_db, m_evt, m_adjmode, m_paused, m_phase;
    int m_run;
    bit exp_sec, exp_min, exp_bmin, exp_bsec;
    bit n_paused, n_mode, n_phase;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            {m_pb1, m_pb2, m_adj1, m_adj2, m_sel1, m_sel2} = '0;
            {m_db, m_evt, m_adjmode, m_paused, m_phase} = '0;
            m_run = 0;
            {exp_sec, exp_min, exp_bmin, exp_bsec} = '0;
        end else begin
            exp_sec  = !m_paused && (m_adjmode ? (tick_2hz && m_sel2) : tick_1hz);
            exp_min  = !m_paused && (m_adjmode ? (tick_2hz && !m_sel2) : (tick_1hz && sec_max));
            n_paused = m_paused ^ m_evt;
            n_phase  = m_adjmode ? (m_phase ^ tick_blink) : 1'b0;
            n_mode   = m_adj2;
            exp_bmin = n_mode && !m_sel2 && n_phase;
            exp_bsec = n_mode && m_sel2 && n_phase;
            if (m_pb2 != m_db) begin
                m_run = m_run + 1;
                if (m_run == DB) begin
                    m_db  = m_pb2;
                    m_evt = m_pb2;
                    m_run = 0;
                end else begin
                    m_evt = 1'b0;
                end
            end else begin
                m_run = 0;
                m_evt = 1'b0;
            end
            m_pb2 = m_pb1;   m_pb1 = pause_btn;
            m_adj2 = m_adj1; m_adj1 = adj;
            m_sel2 = m_sel1; m_sel1 = sel;
            m_paused  = n_paused;
            m_adjmode = n_mode;
            m_phase   = n_phase;
        end
    end

    always @(negedge clk) begin
        chk("m_sec_inc", sec_inc, exp_sec);
        chk("m_min_inc", min_inc, exp_min);
        chk("m_paused", paused, m_paused);
        chk("m_mode", mode, {1'b0, m_adjmode});
        chk("m_blink_min", blink_min, exp_bmin);
        chk("m_blink_sec", blink_sec, exp_bsec);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press_release();
        pause_btn = 1'b1; step(10);
        pause_btn = 1'b0; step(10);
    endtask

    initial begin
        // 1. reset
        #1 rst = 1'b1;
        step(3);
        chk("rst_sec", sec_inc, 0); chk("rst_mode", mode, 0); chk("rst_paused", paused, 0);
        rst = 1'b0;
        step(1);
        chk("rel_mode", mode, 0); chk("rel_blink", {blink_min, blink_sec}, 0);
        $display("reset: outputs cleared");

        // 2. run with and without carry
        step(5);
        tick_1hz = 1'b1; step(1); tick_1hz = 1'b0;
        chk("run_sec", sec_inc, 1); chk("run_nocarry", min_inc, 0);
        step(1);
        chk("run_sec_width", sec_inc, 0);
        sec_max = 1'b1; tick_1hz = 1'b1; step(1); tick_1hz = 1'b0;
        chk("carry_sec", sec_inc, 1); chk("carry_min", min_inc, 1);
        sec_max = 1'b0; step(1);
        chk("carry_width", min_inc, 0);
        $display("run: single increments and carry");

        // 3. debounce with bounce, then final press
        pause_btn = 1'b1; step(2);
        pause_btn = 1'b0; step(2);
        pause_btn = 1'b1; step(6);
        chk("db_early", paused, 0);
        step(1);
        chk("db_exact", paused, 1);
        tick_1hz = 1'b1; step(1); tick_1hz = 1'b0;
        chk("paused_no_inc", sec_inc, 0);
        pause_btn = 1'b0; step(10);
        chk("fall_ignored", paused, 1);
        press_release();
        chk("unpause", paused, 0);
        $display("debounce: bounced press accepted once");

        // 4. adjust minutes
        adj = 1'b1; sel = 1'b0; step(5);
        chk("adj_mode", mode, 1);
        for (int i = 0; i < 3; i++) begin
            tick_2hz = 1'b1; step(1); tick_2hz = 1'b0;
            chk("adj_min", min_inc, 1); chk("adj_min_nosec", sec_inc, 0);
            step(9);
        end
        tick_1hz = 1'b1; sec_max = 1'b1; step(1); tick_1hz = 1'b0; sec_max = 1'b0;
        chk("adj_1hz_ign", {sec_inc, min_inc}, 0);
        tick_blink = 1'b1; step(1); tick_blink = 1'b0;
        chk("blink_min_on", blink_min, 1); chk("blink_sec_off", blink_sec, 0);
        step(3);
        tick_blink = 1'b1; step(1); tick_blink = 1'b0;
        chk("blink_min_off", blink_min, 0);
        $display("adjust: minutes increments and blink");

        // 5. adjust seconds while paused
        sel = 1'b1;
        press_release();
        chk("adj_paused", paused, 1);
        tick_2hz = 1'b1; step(1); tick_2hz = 1'b0;
        chk("adj_frozen", {sec_inc, min_inc}, 0);
        tick_blink = 1'b1; step(1); tick_blink = 1'b0;
        chk("blink_sec_paused", blink_sec, 1);
        adj = 1'b0; step(3);
        chk("leave_mode", mode, 0); chk("leave_blink", {blink_min, blink_sec}, 0);
        chk("leave_paused", paused, 1);
        $display("adjust: seconds frozen while paused, blink runs");

        // 6. simultaneous events
        press_release();
        chk("pre_sim_paused", paused, 0);
        pause_btn = 1'b1; step(6);
        tick_1hz = 1'b1; step(1); tick_1hz = 1'b0;
        chk("sim_pause_sec", sec_inc, 1); chk("sim_pause_flag", paused, 1);
        pause_btn = 1'b0; step(10);
        press_release();
        adj = 1'b1; step(5);
        adj = 1'b0; step(2);
        tick_2hz = 1'b1; step(1); tick_2hz = 1'b0;
        chk("sim_adjfall_sec", sec_inc, 1); chk("sim_adjfall_mode", mode, 0);
        $display("simultaneous: strobes use pre-update state");

        // reset mid-operation, between edges
        #1 rst = 1'b1;
        #1 chk("mid_rst_sec", sec_inc, 0); chk("mid_rst_mode", mode, 0);
        step(2);
        rst = 1'b0;
        step(2);

        // random soak against the model
        for (int c = 0; c < 4000; c++) begin
            tick_1hz   = ($urandom_range(0, 9) == 0);
            tick_2hz   = ($urandom_range(0, 9) == 0);
            tick_blink = ($urandom_range(0, 5) == 0);
            sec_max    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) pause_btn = ~pause_btn;
            if ($urandom_range(0, 79) == 0) adj = ~adj;
            if ($urandom_range(0, 39) == 0) sel = ~sel;
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b1; step(1); rst = 1'b0;
            end
            step(1);
        end
        $display("random: 4000 cycles of mixed stimulus");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
